// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the sequential divider
package div_pkg;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    REPETICAO = 2'd1,
    FINAL     = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             negative;

  // Shift R:Q left, try subtracting the divisor, keep or restore the remainder
  always_comb begin
    shifted  = {r, q[WIDTH-1]};
    trial    = shifted - {2'b00, d};
    negative = trial[WIDTH+1];
    r_next   = negative ? shifted[WIDTH:0] : trial[WIDTH:0];
    q_next   = {q[WIDTH-2:0], ~negative};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed divider, lo = quotient, hi = remainder
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             comeco,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div0,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  div_state_t       state, next_state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic             sa, sq, z;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .d      (b_mag),
    .r_next (r_nx),
    .q_next (q_nx)
  );

  assign busy = (state != ESPERA);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ESPERA;
    else        state <= next_state;
  end

  // Next-state selection: start, 32 steps, one fix-up cycle
  always_comb begin
    next_state = state;
    case (state)
      ESPERA:    if (comeco) next_state = (b == '0) ? FINAL : REPETICAO;
      REPETICAO: if (counter == LAST_STEP) next_state = FINAL;
      FINAL:     next_state = ESPERA;
      default:   next_state = ESPERA;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      r       <= '0;
      q       <= '0;
      b_mag   <= '0;
      sa      <= 1'b0;
      sq      <= 1'b0;
      z       <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        ESPERA: begin
          if (comeco) begin
            sa      <= a[WIDTH-1];
            sq      <= a[WIDTH-1] ^ b[WIDTH-1];
            q       <= a[WIDTH-1] ? -a : a;
            b_mag   <= b[WIDTH-1] ? -b : b;
            r       <= '0;
            counter <= '0;
            z       <= (b == '0);
          end
        end
        REPETICAO: begin
          r       <= r_nx;
          q       <= q_nx;
          counter <= counter + CNT_W'(1);
        end
        FINAL: begin
          done <= 1'b1;
          if (z) begin
            div0 <= 1'b1;
          end else begin
            lo <= sq ? -q : q;
            hi <= sa ? -r[WIDTH-1:0] : r[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        comeco;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        done, div0, busy;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .comeco (comeco),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .done   (done),
    .div0   (div0),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a division, optionally poke comeco again at poke_edge, wait for done
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_z, input int exp_lat, input int poke_edge);
    int   cyc;
    logic busy_drop;
    @(negedge clock);
    a = av; b = bv; comeco = 1'b1;
    @(posedge clock); #1;
    comeco = 1'b0;
    check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    busy_drop = 1'b0;
    while (!done && cyc < 60) begin
      if (poke_edge > 0 && cyc == poke_edge - 1) begin
        a = 32'd9; b = 32'd3; comeco = 1'b1;
      end else begin
        comeco = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
      if (!done && !busy) busy_drop = 1'b1;
    end
    comeco = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_div0"}, {31'b0, div0}, {31'b0, exp_z});
    check({tag, "_busy_drop"}, {31'b0, busy_drop}, 32'd0);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    check({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    check({tag, "_div0_clr"}, {31'b0, div0}, 32'd0);
    check({tag, "_lo_hold"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0; comeco = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div0", {31'b0, div0}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    do_div("pos_pos",   32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0, 33, 0);
    do_div("neg_pos",   32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, 0);
    do_div("pos_neg",   32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 33, 0);
    do_div("div_zero",  32'd5,        32'd0,        32'hFFFFFFF2, 32'h00000002, 1'b1, 1,  0);
    do_div("overflow",  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33, 0);
    do_div("small",     32'd3,        32'd10,       32'h00000000, 32'h00000003, 1'b0, 33, 0);
    do_div("neg_neg",   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 33, 0);
    do_div("ignore",    32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0, 33, 5);

    // Reset in the middle of the tenth iteration
    @(negedge clock);
    a = 32'd100; b = 32'd7; comeco = 1'b1;
    @(posedge clock); #1;
    comeco = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (3) begin
        @(posedge clock); #1;
        if (done) saw_done = 1'b1;
      end
      check("midrst_no_done", {31'b0, saw_done}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    do_div("after_rst", 32'd9, 32'd3, 32'h00000003, 32'h00000000, 1'b0, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
